fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entries (legal 2..4).
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports o_imem_req  output  1 and o_imem_addr  output  32, the fetch request and its word address.
REQ-006 SHALL have port i_imem_gnt  input  1; a request is accepted when o_imem_req and i_imem_gnt are both high.
REQ-007 SHALL have ports i_imem_rvalid  input  1 and i_imem_rdata  input  32; responses arrive in order, no earlier than 1 cycle after grant.
REQ-008 SHALL have ports o_if_valid  output  1, o_if_instr  output  32, o_if_pc  output  32, and i_id_ready  input  1 toward decode.
REQ-009 SHALL have ports i_redirect  input  1 and i_redirect_pc  input  32 for branch, jump and trap redirection.

Function
REQ-010 SHALL implement FSM states BOOT, RUN and DRAIN.
REQ-011 SHALL enter BOOT on reset and move to RUN on the first clock after reset deasserts, with no request in BOOT.
REQ-012 In RUN, SHALL assert o_imem_req whenever outstanding + occupancy < FIFO_DEPTH (credit rule), so the FIFO never overflows.
REQ-013 SHALL advance the fetch PC by 4 on each grant, wrapping 32'hFFFF_FFFC to 32'h0000_0000; o_imem_addr[1:0] SHALL be 2'b00.
REQ-014 SHALL write each accepted response, with its PC, into the FIFO; it becomes visible on o_if_valid/o_if_instr/o_if_pc the cycle after i_imem_rvalid.
REQ-015 SHALL pop the FIFO head when o_if_valid and i_id_ready are both high; a push and a pop in the same cycle SHALL both take effect.
REQ-016 SHALL hold o_if_instr and o_if_pc stable while o_if_valid is high and i_id_ready is low.
REQ-017 On i_redirect, SHALL flush the FIFO, load the fetch PC with {i_redirect_pc[31:2],2'b00}, and deassert o_if_valid next cycle.
REQ-018 i_redirect SHALL take priority over any same-cycle grant, pop or push; a same-cycle grant counts as outstanding and is discarded.
REQ-019 On redirect, SHALL go to DRAIN if outstanding > 0 after that cycle, otherwise stay in RUN and request the new PC next cycle.
REQ-020 In DRAIN, SHALL hold o_imem_req low, drop every response, and return to RUN when outstanding reaches 0.
REQ-021 A redirect during DRAIN SHALL update the target PC and remain in DRAIN.
REQ-022 The outstanding counter SHALL be wide enough for FIFO_DEPTH.
REQ-023 An rvalid with outstanding = 0 SHALL be ignored and SHALL be flagged by a simulation-only assertion.

Reset
REQ-024 On i_rst, SHALL immediately and asynchronously set: state=BOOT, fetch PC=RESET_PC, FIFO empty, outstanding=0, o_imem_req=0, o_imem_addr=RESET_PC, o_if_valid=0, o_if_instr=0, o_if_pc=0.
REQ-025 Reset mid-transaction SHALL forget all outstanding requests; the memory is reset together with this block.

Configuration
REQ-026 Macro FETCH_BUS_ERR_EN, when defined, SHALL add ports i_imem_err  input  1 (qualified by i_imem_rvalid) and o_if_fault  output  1.
REQ-027 With FETCH_BUS_ERR_EN defined, SHALL store the error bit per FIFO entry, present it as o_if_fault with that entry, and stop requesting until the next redirect.
REQ-028 Without FETCH_BUS_ERR_EN, those ports and storage SHALL not exist, and response data SHALL be accepted unconditionally.

Structure
REQ-029 The shared header/package SHALL hold the FSM state encodings, the default RESET_PC value, and the instruction width constant.
REQ-030 The FIFO SHALL be a sub-module fetch_fifo (parameterised depth, width 64 or 65, registered output).

Verification
REQ-031 Reset release, gnt tied high, 1-cycle memory at 0x0 = 0x00000013 -> first req at 0x0 cycle 2 after release; o_if_valid with pc 0x0, instr 0x00000013 cycle 4.
REQ-032 i_id_ready held low 10 cycles -> exactly 2 requests issued, 0x0 and 0x4, then o_imem_req low; FIFO holds pc 0x0 and 0x4 with no loss.
REQ-033 Redirect to 0x1002 with 2 requests outstanding -> DRAIN, both stale responses dropped, next request at 0x1000, first valid pc 0x1000.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
REQ-035 Redirect, grant and i_id_ready pop all in one cycle -> FIFO empty next cycle, the granted request's response discarded, target fetched.
REQ-036 With FETCH_BUS_ERR_EN, error on the response for 0x8 -> o_if_fault=1 with pc 0x8, no further requests until redirect to 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg                                                        |
// | Shared fetch-unit types: FSM encodings, reset PC, widths.        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package fetch_pkg;

   localparam int          c_INSTR_W  = 32;
   localparam int          c_PC_W     = 32;
   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   // Word-aligned increment; wraps 0xFFFF_FFFC -> 0x0000_0000.
   function automatic logic [c_PC_W-1:0] f_next_pc(input logic [c_PC_W-1:0] pc);
      return {pc[c_PC_W-1:2] + 30'd1, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo                                                       |
// | Shift-register instruction buffer; head entry drives the output. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_fifo #(
   parameter int   DEPTH = 2,
   parameter int   WIDTH = 64,
   localparam int  CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem   [DEPTH];
   logic [WIDTH-1:0] w_shift [DEPTH];
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_wr_idx;

   // Each entry takes its upper neighbour on a pop; the last one has none.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi < DEPTH - 1) begin : g_shift
         assign w_shift[gi] = r_mem[gi+1];
      end else begin : g_last
         assign w_shift[gi] = r_mem[gi];
      end
   end

   assign w_wr_idx = i_pop ? (r_cnt - CNT_W'(1)) : r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_pop) r_mem[i] <= w_shift[i];
            if (i_push && (CNT_W'(i) == w_wr_idx)) r_mem[i] <= i_wdata;
         end
         r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_valid = (r_cnt != '0);
   assign o_rdata = r_mem[0];
   assign o_count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit                                                       |
// | Credit-based instruction fetch with redirect/drain handling.     |
// | Optional macro FETCH_BUS_ERR_EN adds per-entry bus-error fault.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = c_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   output logic                 o_imem_req,
   output logic [c_PC_W-1:0]    o_imem_addr,
   input  logic                 i_imem_gnt,
   input  logic                 i_imem_rvalid,
   input  logic [c_INSTR_W-1:0] i_imem_rdata,
`ifdef FETCH_BUS_ERR_EN
   input  logic                 i_imem_err,
   output logic                 o_if_fault,
`endif
   output logic                 o_if_valid,
   output logic [c_INSTR_W-1:0] o_if_instr,
   output logic [c_PC_W-1:0]    o_if_pc,
   input  logic                 i_id_ready,
   input  logic                 i_redirect,
   input  logic [c_PC_W-1:0]    i_redirect_pc
);

   localparam int c_OUT_W = $clog2(FIFO_DEPTH + 1);
`ifdef FETCH_BUS_ERR_EN
   localparam int c_ENTRY_W = c_PC_W + c_INSTR_W + 1;
`else
   localparam int c_ENTRY_W = c_PC_W + c_INSTR_W;
`endif
   localparam logic [c_PC_W-1:0] c_RST_ADDR = {RESET_PC[c_PC_W-1:2], 2'b00};

   fetch_state_e         r_state, w_state_nxt;
   logic [c_PC_W-1:0]    r_pc;
   logic [c_PC_W-1:0]    r_resp_pc;
   logic [c_OUT_W-1:0]   r_outst, w_outst_nxt;
   logic [c_OUT_W-1:0]   w_fifo_cnt;
   logic [c_ENTRY_W-1:0] w_wdata, w_rdata;
   logic [c_PC_W-1:0]    w_target;
   logic                 w_req, w_gnt, w_resp, w_push, w_pop, w_credit, w_stop;

   assign w_target = {i_redirect_pc[c_PC_W-1:2], 2'b00};
   assign w_credit = ({1'b0, r_outst} + {1'b0, w_fifo_cnt}) < (c_OUT_W+1)'(FIFO_DEPTH);
   assign w_req    = (r_state == ST_RUN) && w_credit && !w_stop;
   assign w_gnt    = w_req && i_imem_gnt;
   assign w_resp   = i_imem_rvalid && (r_outst != '0);
   // Responses arriving while draining, or alongside a redirect, are stale.
   assign w_push   = w_resp && (r_state == ST_RUN) && !i_redirect;
   assign w_pop    = o_if_valid && i_id_ready && !i_redirect;

   always_comb begin
      w_outst_nxt = r_outst;
      if (w_gnt && !w_resp)      w_outst_nxt = r_outst + c_OUT_W'(1);
      else if (!w_gnt && w_resp) w_outst_nxt = r_outst - c_OUT_W'(1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_BOOT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT:  w_state_nxt = ST_RUN;
         ST_RUN:   if (i_redirect && (w_outst_nxt != '0)) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (!i_redirect && (w_outst_nxt == '0)) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_BOOT;
      endcase
   end

   // r_resp_pc tracks the PC of the oldest live outstanding request.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc      <= c_RST_ADDR;
         r_resp_pc <= c_RST_ADDR;
         r_outst   <= '0;
      end else begin
         r_outst <= w_outst_nxt;
         if (i_redirect) begin
            r_pc      <= w_target;
            r_resp_pc <= w_target;
         end else begin
            if (w_gnt)  r_pc      <= f_next_pc(r_pc);
            if (w_push) r_resp_pc <= f_next_pc(r_resp_pc);
         end
      end
   end

`ifdef FETCH_BUS_ERR_EN
   logic r_err_stop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                     r_err_stop <= 1'b0;
      else if (i_redirect)           r_err_stop <= 1'b0;
      else if (w_push && i_imem_err) r_err_stop <= 1'b1;
   end

   assign w_stop     = r_err_stop;
   assign w_wdata    = {i_imem_err, r_resp_pc, i_imem_rdata};
   assign o_if_fault = o_if_valid && w_rdata[c_ENTRY_W-1];
`else
   assign w_stop  = 1'b0;
   assign w_wdata = {r_resp_pc, i_imem_rdata};
`endif

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_valid (o_if_valid),
      .o_rdata (w_rdata),
      .o_count (w_fifo_cnt)
   );

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_if_instr  = w_rdata[c_INSTR_W-1:0];
   assign o_if_pc     = w_rdata[c_INSTR_W +: c_PC_W];

`ifndef SYNTHESIS
   a_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
      i_imem_rvalid |-> (r_outst != '0))
      else $error("fetch_unit: rvalid with no outstanding request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit                                                    |
// | Directed bench with memory model and expected-output queue.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, gnt, rvalid, ready, redirect;
   logic [31:0] rdata, redirect_pc;
   logic        req, if_valid;
   logic [31:0] addr, instr, pc;
`ifdef FETCH_BUS_ERR_EN
   logic        imem_err, if_fault;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (req),
      .o_imem_addr   (addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
`ifdef FETCH_BUS_ERR_EN
      .i_imem_err    (imem_err),
      .o_if_fault    (if_fault),
`endif
      .o_if_valid    (if_valid),
      .o_if_instr    (instr),
      .o_if_pc       (pc),
      .i_id_ready    (ready),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc)
   );

   typedef struct {logic [31:0] addr; int ep;} mreq_t;
   typedef struct {logic [31:0] pc; logic [31:0] ins; logic flt;} exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   logic [31:0] gnt_log[$];
   logic [31:0] model_pc, resp_addr, err_addr;
   logic [31:0] exp_wrap [3];
   int          epoch, resp_ep, n_gnt, n_checks, n_fail;
   bit          mem_en, resp_err, err_stop;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 4) | 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: present memory response, check outputs, update model, step edge.
   task automatic cycle();
      mreq_t m;
      if (mem_en && mem_q.size() != 0) begin
         m         = mem_q.pop_front();
         rvalid    = 1'b1;
         rdata     = mem_word(m.addr);
         resp_addr = m.addr;
         resp_ep   = m.ep;
         resp_err  = (m.addr == err_addr);
      end else begin
         rvalid   = 1'b0;
         rdata    = 32'h0;
         resp_err = 1'b0;
      end
`ifdef FETCH_BUS_ERR_EN
      imem_err = resp_err;
`endif
      #1;
      if (err_stop) chk("req_after_err", 32'(req), 32'd0);
      if (req) chk("req_addr", addr, model_pc);
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (if_valid && exp_q.size() != 0) begin
         chk("if_pc", pc, exp_q[0].pc);
         chk("if_instr", instr, exp_q[0].ins);
`ifdef FETCH_BUS_ERR_EN
         chk("if_fault", 32'(if_fault), 32'(exp_q[0].flt));
`endif
      end
      if (if_valid && ready && !redirect && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rvalid && resp_ep == epoch && !redirect) begin
         exp_q.push_back('{resp_addr, mem_word(resp_addr), resp_err});
         if (resp_err) err_stop = 1'b1;
      end
      if (req && gnt) begin
         n_gnt++;
         gnt_log.push_back(addr);
         mem_q.push_back('{model_pc, epoch});
         model_pc = model_pc + 32'd4;
      end
      if (redirect) begin
         epoch++;
         exp_q.delete();
         model_pc = {redirect_pc[31:2], 2'b00};
         err_stop = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      int k = 0;
      while (!if_valid && k < 30) begin
         cycle();
         k++;
      end
      chk({tag, "_valid"}, 32'(if_valid), 32'd1);
      chk(tag, pc, exp_pc);
   endtask

   task automatic drain_scn(input logic [31:0] t1, input bit twice,
                            input logic [31:0] t2, input logic [31:0] first_pc);
      mem_en = 1'b0;
      ready  = 1'b1;
      repeat (5) cycle();
      chk("drain_outstanding", 32'(mem_q.size()), 32'd2);
      redirect = 1'b1; redirect_pc = t1; cycle(); redirect = 1'b0;
      cycle();
      chk("drain_noreq", 32'(req), 32'd0);
      if (twice) begin
         redirect = 1'b1; redirect_pc = t2; cycle(); redirect = 1'b0;
         chk("drain_hold_noreq", 32'(req), 32'd0);
      end
      mem_en = 1'b1;
      wait_valid("drain_first_pc", first_pc);
   endtask

   task automatic clear_model();
      mem_q.delete();
      exp_q.delete();
      model_pc = 32'h0;
      rvalid   = 1'b0;
      err_stop = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b0; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0; ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0; mem_en = 1'b1; epoch = 0;
      model_pc = 32'h0; err_stop = 1'b0; n_gnt = 0; n_checks = 0; n_fail = 0;
      err_addr = 32'h1; resp_err = 1'b0; resp_ep = 0; resp_addr = 32'h0;
`ifdef FETCH_BUS_ERR_EN
      imem_err = 1'b0;
`endif
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h0);

      // Release with decode stalled: first entry after 3 clocks, only 2 fetches.
      rst = 1'b0;
      chk("boot_noreq", 32'(req), 32'd0);
      repeat (3) cycle();
      chk("first_valid", 32'(if_valid), 32'd1);
      chk("first_pc", pc, 32'h0);
      chk("first_instr", instr, 32'h0000_0013);
      repeat (7) cycle();
      chk("grants_ready_low", 32'(n_gnt), 32'd2);
      chk("req_low_full", 32'(req), 32'd0);
      chk("head_held_pc", pc, 32'h0);
      ready = 1'b1;
      cycle();
      chk("second_pc", pc, 32'h4);
      repeat (8) cycle();

      drain_scn(32'h0000_1002, 1'b0, 32'h0, 32'h0000_1000);
      repeat (6) cycle();
      drain_scn(32'h0000_3000, 1'b1, 32'h0000_4006, 32'h0000_4004);
      repeat (4) cycle();

      // Redirect coinciding with a grant and a pop.
      k = 0;
      while (!(req && if_valid) && k < 20) begin
         cycle();
         k++;
      end
      chk("rgp_setup", 32'(req && if_valid), 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0000_0500; cycle(); redirect = 1'b0;
      chk("rgp_flushed", 32'(if_valid), 32'd0);
      wait_valid("rgp_target_pc", 32'h0000_0500);

      // Address wrap at the top of memory.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; cycle(); redirect = 1'b0;
      gnt_log.delete();
      repeat (10) cycle();
      exp_wrap[0] = 32'hFFFF_FFF8;
      exp_wrap[1] = 32'hFFFF_FFFC;
      exp_wrap[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++)
         chk($sformatf("wrap_addr%0d", i), (gnt_log.size() > i) ? gnt_log[i] : 32'hDEAD_BEEF,
             exp_wrap[i]);

      // Asynchronous reset in the middle of traffic.
      #3 rst = 1'b1;
      #1;
      chk("async_rst_req", 32'(req), 32'd0);
      chk("async_rst_valid", 32'(if_valid), 32'd0);
      chk("async_rst_addr", addr, 32'h0);
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_instr", instr, 32'h0);
      clear_model();
`ifdef FETCH_BUS_ERR_EN
      err_addr = 32'h8;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_valid("restart_pc", 32'h0);

`ifdef FETCH_BUS_ERR_EN
      k = 0;
      while (!(if_valid && pc == 32'h8) && k < 20) begin
         cycle();
         k++;
      end
      chk("err_pc", pc, 32'h8);
      chk("err_fault", 32'(if_fault), 32'd1);
      repeat (10) cycle();
      chk("err_stopped", 32'(req), 32'd0);
      redirect = 1'b1; redirect_pc = 32'h0000_0100; cycle(); redirect = 1'b0;
      wait_valid("err_redirect_pc", 32'h0000_0100);
`endif
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
